csr_trap_unit: RTL and testbench

//  Machine-mode CSR file and trap sequencer; the source of the PC unit's control-flow redirects.

---
 rtl/csr_pkg.sv | 42 ++++
 rtl/csr_counter64.sv | 22 ++
 rtl/csr_trap_unit.sv | 179 +++++++++++++++++
 tb/tb_csr_trap_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR addresses, field positions, cause codes and trap FSM states
// for the machine-mode CSR file.
package csr_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;

  // funct3[1:0]; funct3[2] only selects rs1 vs zimm upstream
  localparam logic [1:0] CSROP_RW = 2'b01;
  localparam logic [1:0] CSROP_RS = 2'b10;
  localparam logic [1:0] CSROP_RC = 2'b11;

  typedef enum logic {RUN, SLEEP} trap_state_t;

  function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                            input logic [31:0] old,
                                            input logic [31:0] wd);
    logic [31:0] r;
    case (op)
      CSROP_RS: r = old | wd;
      CSROP_RC: r = old & ~wd;
      default:  r = wd;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves;
// a write to either half takes priority over the increment.
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] q
);
  logic [63:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     r_q <= '0;
    else if (wr_lo) r_q[31:0]  <= wdata;
    else if (wr_hi) r_q[63:32] <= wdata;
    else if (inc)   r_q <= r_q + 64'd1;
  end

  assign q = r_q;
endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer: executes Zicsr/MRET/WFI from EX,
// arbitrates external/timer interrupts and drives trap/return redirects.
module csr_trap_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HARTID      = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        im_stall,
  input  logic        dm_stall,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        csr_en,
  input  logic [2:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        is_mret,
  input  logic        is_wfi,
  input  logic        instret_inc,
  input  logic        ext_irq,
  input  logic        tmr_irq,
  output logic [31:0] csr_rdata,
  output logic        redirect_trap,
  output logic [31:0] trap_pc,
  output logic        redirect_ret,
  output logic [31:0] ret_pc,
  output logic        flush,
  output logic        wfi_stall
);
  trap_state_t r_state, w_state_nxt;
  logic        r_ext_s1, r_ext_s2;
  logic        r_mie, r_mpie, r_mtie, r_meie;
  logic [31:2] r_mtvec, r_mepc, r_mepc_shadow;
  logic [31:0] r_mcause;
  logic [63:0] w_mcycle, w_minstret;
  logic [31:0] w_mstatus, w_mie_v, w_mip_v, w_rdata, w_wval, w_trap_epc;
  logic        w_adv, w_pend, w_take, w_trap, w_mret, w_wfi, w_csr_fire, w_wr;
  logic        w_unused;

  assign w_unused  = csr_op[2];
  assign w_adv     = ex_valid & ~im_stall & ~dm_stall;
  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
  assign w_mie_v   = {20'b0, r_meie, 3'b0, r_mtie, 7'b0};
  assign w_mip_v   = {20'b0, r_ext_s2, 3'b0, tmr_irq, 7'b0};
  assign w_pend    = |(w_mie_v & w_mip_v);
  assign w_take    = r_mie & w_pend;

  always_comb begin
    w_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:   w_rdata = w_mstatus;
      CSR_MIE:       w_rdata = w_mie_v;
      CSR_MIP:       w_rdata = w_mip_v;
      CSR_MTVEC:     w_rdata = {r_mtvec, 2'b00};
      CSR_MEPC:      w_rdata = {r_mepc, 2'b00};
      CSR_MCAUSE:    w_rdata = r_mcause;
      CSR_MHARTID:   w_rdata = HARTID;
      CSR_MCYCLE:    w_rdata = w_mcycle[31:0];
      CSR_MCYCLEH:   w_rdata = w_mcycle[63:32];
      CSR_MINSTRET:  w_rdata = w_minstret[31:0];
      CSR_MINSTRETH: w_rdata = w_minstret[63:32];
      default:       w_rdata = '0;
    endcase
  end

  // Priority trap > MRET > WFI > CSR write; only one event fires per cycle
  always_comb begin
    w_state_nxt = r_state;
    w_trap      = 1'b0;
    w_mret      = 1'b0;
    w_wfi       = 1'b0;
    w_csr_fire  = 1'b0;
    w_trap_epc  = ex_pc;
    case (r_state)
      RUN: begin
        if (w_take & w_adv)       w_trap = 1'b1;
        else if (is_mret & w_adv) w_mret = 1'b1;
        else if (is_wfi & w_adv) begin
          w_wfi       = 1'b1;
          w_state_nxt = SLEEP;
        end
        else if (csr_en & w_adv)  w_csr_fire = 1'b1;
      end
      SLEEP: begin
        if (w_pend) begin
          w_state_nxt = RUN;
          if (r_mie) begin
            w_trap     = 1'b1;
            w_trap_epc = {r_mepc_shadow, 2'b00};
          end
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign w_wr   = w_csr_fire & ((csr_op[1:0] == CSROP_RW) |
                  ((csr_op[1:0] != 2'b00) & (csr_wdata != 32'd0)));
  assign w_wval = csr_apply(csr_op[1:0], w_rdata, csr_wdata);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= RUN;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ext_s1      <= 1'b0;
      r_ext_s2      <= 1'b0;
      r_mie         <= 1'b0;
      r_mpie        <= 1'b0;
      r_mtie        <= 1'b0;
      r_meie        <= 1'b0;
      r_mtvec       <= MTVEC_RESET[31:2];
      r_mepc        <= '0;
      r_mepc_shadow <= '0;
      r_mcause      <= '0;
    end else begin
      r_ext_s1 <= ext_irq;
      r_ext_s2 <= r_ext_s1;
      if (w_trap) begin
        r_mepc   <= w_trap_epc[31:2];
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
        r_mcause <= (r_meie & r_ext_s2) ? MCAUSE_MEI : MCAUSE_MTI;
      end else if (w_mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else if (w_wfi) begin
        r_mepc_shadow <= ex_pc[31:2] + 30'd1;
      end else if (w_wr) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            r_mie  <= w_wval[MSTATUS_MIE];
            r_mpie <= w_wval[MSTATUS_MPIE];
          end
          CSR_MIE: begin
            r_mtie <= w_wval[MIE_MTIE];
            r_meie <= w_wval[MIE_MEIE];
          end
          CSR_MTVEC:  r_mtvec  <= w_wval[31:2];
          CSR_MEPC:   r_mepc   <= w_wval[31:2];
          CSR_MCAUSE: r_mcause <= w_wval;
          default: ;
        endcase
      end
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .wr_lo (w_wr & (csr_addr == CSR_MCYCLE)),
    .wr_hi (w_wr & (csr_addr == CSR_MCYCLEH)),
    .wdata (w_wval),
    .q     (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .reset (reset),
    .inc   (instret_inc & ~im_stall & ~dm_stall),
    .wr_lo (w_wr & (csr_addr == CSR_MINSTRET)),
    .wr_hi (w_wr & (csr_addr == CSR_MINSTRETH)),
    .wdata (w_wval),
    .q     (w_minstret)
  );

  assign csr_rdata     = w_rdata;
  assign redirect_trap = w_trap;
  assign trap_pc       = {r_mtvec, 2'b00};
  assign redirect_ret  = w_mret;
  assign ret_pc        = {r_mepc, 2'b00};
  assign flush         = w_trap | w_mret;
  assign wfi_stall     = (r_state == SLEEP);
endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: stimulus queues expected reads and
// redirects, a negedge monitor pops and compares them.
module tb_csr_trap_unit;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0203;
  localparam logic [31:0] HID       = 32'd5;

  logic        clk, reset, im_stall, dm_stall, ex_valid, csr_en;
  logic        is_mret, is_wfi, instret_inc, ext_irq, tmr_irq;
  logic [31:0] ex_pc, csr_wdata, csr_rdata, trap_pc, ret_pc;
  logic [2:0]  csr_op;
  logic [11:0] csr_addr;
  logic        redirect_trap, redirect_ret, flush, wfi_stall;

  // kind 0: sampled value (sel picks the signal), 1: trap redirect, 2: return redirect
  typedef struct {
    int          kind;
    int          sel;
    logic [31:0] exp;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic rd_stb = 1'b0;

  csr_trap_unit #(.MTVEC_RESET(MTVEC_RST), .HARTID(HID)) dut (
    .clk(clk), .reset(reset), .im_stall(im_stall), .dm_stall(dm_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .csr_en(csr_en), .csr_op(csr_op),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .is_mret(is_mret), .is_wfi(is_wfi),
    .instret_inc(instret_inc), .ext_irq(ext_irq), .tmr_irq(tmr_irq),
    .csr_rdata(csr_rdata), .redirect_trap(redirect_trap), .trap_pc(trap_pc),
    .redirect_ret(redirect_ret), .ret_pc(ret_pc), .flush(flush), .wfi_stall(wfi_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (redirect_trap | redirect_ret | flush) begin
      checks++;
      if (q.size() == 0 || q[0].kind == 0) begin
        errors++;
        $display("FAIL spurious_redirect trap=%0b ret=%0b flush=%0b cyc=%0d required none",
                 redirect_trap, redirect_ret, flush, cyc);
      end else begin
        e   = q.pop_front();
        act = (e.kind == 1) ? trap_pc : ret_pc;
        if ((e.kind == 1 && !(redirect_trap && !redirect_ret && flush)) ||
            (e.kind == 2 && !(redirect_ret && !redirect_trap && flush)) ||
            act !== e.exp || (e.cyc >= 0 && e.cyc != cyc)) begin
          errors++;
          $display("FAIL %s got pc=%h t=%0b r=%0b f=%0b cyc=%0d required pc=%h kind=%0d cyc=%0d",
                   e.nm, act, redirect_trap, redirect_ret, flush, cyc, e.exp, e.kind, e.cyc);
        end
      end
    end
    if (rd_stb) begin
      checks++;
      if (q.size() == 0 || q[0].kind != 0) begin
        errors++;
        $display("FAIL read_order queue=%0d required a pending read", q.size());
      end else begin
        e = q.pop_front();
        case (e.sel)
          1:       act = {31'b0, wfi_stall};
          2:       act = {28'b0, wfi_stall, flush, redirect_trap, redirect_ret};
          3:       act = trap_pc;
          4:       act = ret_pc;
          default: act = csr_rdata;
        endcase
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s got=%h required=%h", e.nm, act, e.exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input string nm, input int sel, input logic [11:0] a, input logic [31:0] e);
    exp_t x;
    x.kind = 0; x.sel = sel; x.exp = e; x.cyc = -1; x.nm = nm;
    csr_addr = a;
    q.push_back(x);
    rd_stb = 1'b1;
    tick(1);
    rd_stb = 1'b0;
  endtask

  task automatic push_redir(input string nm, input int kind, input logic [31:0] pc, input int c);
    exp_t x;
    x.kind = kind; x.sel = 0; x.exp = pc; x.cyc = c; x.nm = nm;
    q.push_back(x);
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while (q.size() != 0 && n < maxc) begin
      tick(1);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: still pending after %0d cycles, required an event", q[0].nm, maxc);
      q.delete();
    end
  endtask

  task automatic csr_do(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd);
    ex_valid = 1'b1; csr_en = 1'b1; csr_op = op; csr_addr = a; csr_wdata = wd;
    tick(1);
    ex_valid = 1'b0; csr_en = 1'b0;
  endtask

  task automatic wfi_at(input logic [31:0] pc);
    ex_valid = 1'b1; is_wfi = 1'b1; ex_pc = pc;
    tick(1);
    ex_valid = 1'b0; is_wfi = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; im_stall = 1'b0; dm_stall = 1'b0; ex_valid = 1'b0; ex_pc = '0;
    csr_en = 1'b0; csr_op = '0; csr_addr = '0; csr_wdata = '0; is_mret = 1'b0;
    is_wfi = 1'b0; instret_inc = 1'b0; ext_irq = 1'b0; tmr_irq = 1'b0;
    tick(2);
    rd("rst_ctrl", 2, 12'h000, 32'h0);
    rd("rst_trap_pc", 3, 12'h000, 32'h0000_0200);
    rd("rst_ret_pc", 4, 12'h000, 32'h0);
    reset = 1'b1;
    tick(1);
    rd("rst_mtvec", 0, 12'h305, 32'h0000_0200);
    rd("mhartid", 0, 12'hF14, HID);
    rd("rst_mstatus", 0, 12'h300, 32'h0000_1800);
    rd("rst_minstret", 0, 12'hB02, 32'h0);

    // two retiring cycles, one stalled
    instret_inc = 1'b1; tick(2);
    dm_stall = 1'b1; tick(1);
    dm_stall = 1'b0; instret_inc = 1'b0;
    rd("minstret", 0, 12'hB02, 32'd2);

    // external interrupt trap
    csr_do(3'b001, 12'h305, 32'h100);
    csr_do(3'b010, 12'h304, 32'h800);
    csr_do(3'b010, 12'h300, 32'h8);
    ex_valid = 1'b1; ex_pc = 32'h40;
    push_redir("ext_trap", 1, 32'h100, cyc + 2);
    ext_irq = 1'b1;
    wait_drain(10);
    ex_valid = 1'b0;
    rd("ext_mepc", 0, 12'h341, 32'h40);
    rd("ext_mcause", 0, 12'h342, 32'h8000_000B);
    rd("ext_mstatus", 0, 12'h300, 32'h0000_1880);
    ext_irq = 1'b0;
    tick(3);

    // MRET held by dm_stall for four cycles
    ex_valid = 1'b1; is_mret = 1'b1; ex_pc = 32'h44; dm_stall = 1'b1;
    push_redir("mret", 2, 32'h40, cyc + 4);
    tick(4);
    dm_stall = 1'b0;
    wait_drain(5);
    ex_valid = 1'b0; is_mret = 1'b0;
    rd("mret_mstatus", 0, 12'h300, 32'h0000_1888);

    // timer trap squashes a simultaneous CSR write
    csr_do(3'b010, 12'h304, 32'h80);
    ex_valid = 1'b1; csr_en = 1'b1; csr_op = 3'b001; csr_addr = 12'h305;
    csr_wdata = 32'h200; ex_pc = 32'h60; tmr_irq = 1'b1;
    push_redir("tmr_trap", 1, 32'h100, cyc);
    tick(1);
    ex_valid = 1'b0; csr_en = 1'b0; tmr_irq = 1'b0;
    wait_drain(2);
    rd("tmr_mtvec_kept", 0, 12'h305, 32'h100);
    rd("tmr_mepc", 0, 12'h341, 32'h60);
    rd("tmr_mcause", 0, 12'h342, 32'h8000_0007);
    rd("mscratch_unimpl", 0, 12'h340, 32'h0);
    csr_do(3'b011, 12'h304, 32'h80);
    rd("mie_rc", 0, 12'h304, 32'h800);

    // WFI with MIE=0: wake without trap
    wfi_at(32'h80);
    rd("wfi_sleep0", 1, 12'h000, 32'h1);
    ext_irq = 1'b1;
    tick(4);
    rd("wfi_wake0", 1, 12'h000, 32'h0);
    ext_irq = 1'b0;
    tick(3);

    // WFI with MIE=1: wake with trap, mepc = WFI pc + 4
    csr_do(3'b010, 12'h300, 32'h8);
    wfi_at(32'h80);
    rd("wfi_sleep1", 1, 12'h000, 32'h1);
    push_redir("wfi_trap", 1, 32'h100, -1);
    ext_irq = 1'b1;
    wait_drain(10);
    rd("wfi_mepc", 0, 12'h341, 32'h84);
    rd("wfi_mcause", 0, 12'h342, 32'h8000_000B);
    ext_irq = 1'b0;
    tick(3);

    // mcycle carry into mcycleh
    csr_do(3'b001, 12'hB00, 32'hFFFF_FFFF);
    csr_do(3'b001, 12'hB80, 32'h0);
    tick(1);
    rd("mcycle_wrap", 0, 12'hB00, 32'h0);
    rd("mcycleh_carry", 0, 12'hB80, 32'h1);
    csr_do(3'b010, 12'h305, 32'h0);
    rd("rs_zero_mtvec", 0, 12'h305, 32'h100);

    // async reset while sleeping
    wfi_at(32'h90);
    rd("wfi_sleep2", 1, 12'h000, 32'h1);
    reset = 1'b0;
    rd("reset_in_sleep", 2, 12'h000, 32'h0);
    reset = 1'b1;
    tick(1);
    rd("post_reset_mtvec", 0, 12'h305, 32'h0000_0200);
    rd("post_reset_mie", 0, 12'h304, 32'h0);
    wait_drain(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
